// File: rtl/prog_loader_pkg.sv
// Shared constants, state encodings and small helpers for the UART program loader.
package prog_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         RAM_DEPTH = 16;
   localparam int         ADDR_W    = $clog2(RAM_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CHECK = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Running modulo-256 checksum of the program image.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

   // States in which the CPU must be held in reset.
   function automatic logic holds_cpu(input loader_state_t s);
      return (s == ST_LOAD) || (s == ST_CHECK) || (s == ST_ERROR);
   endfunction

endpackage

// File: rtl/prog_loader_uart_rx.sv
// 8N1 UART receiver: input synchronizer, mid-bit sampling, one-cycle byte_valid strobe.
module uart_rx
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic             rx_p0, rx_p1, rx_p2;
   logic             fall;
   rx_state_t        st;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_p0;
   logic             sample_data, sample_stop;

   // Stage p0/p1: synchronizer; p2 keeps the previous synchronized value for edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_p0 <= 1'b1;
         rx_p1 <= 1'b1;
         rx_p2 <= 1'b1;
      end else begin
         rx_p0 <= rx;
         rx_p1 <= rx_p0;
         rx_p2 <= rx_p1;
      end
   end

   assign fall        = rx_p2 & ~rx_p1;
   assign sample_data = (st == RX_DATA) && (cnt == BIT_LAST);
   assign sample_stop = (st == RX_STOP) && (cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= RX_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         case (st)
            RX_IDLE: begin
               if (fall) begin
                  st  <= RX_START;
                  cnt <= '0;
               end
            end
            RX_START: begin
               if (cnt == HALF_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  // A start bit that is high again at mid-bit was a glitch.
                  st      <= rx_p1 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) st <= RX_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt        <= '0;
                  st         <= RX_IDLE;
                  byte_valid <= 1'b1;
                  frame_err  <= ~rx_p1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: st <= RX_IDLE;
         endcase
      end
   end

   // Data path carries no reset; byte_valid qualifies it.
   always_ff @(posedge clk) begin
      if (sample_data) shift_p0 <= {rx_p1, shift_p0[7:1]};
      if (sample_stop) rx_byte  <= shift_p0;
   end

endmodule

// File: rtl/prog_loader.sv
// Loads a 16-byte program image received over UART into CPU RAM, verifying a trailing checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              prog,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        programm_input,
   output logic              cpu_reset,
   output logic              load_done,
   output logic              load_error
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(RAM_DEPTH - 1);

   logic              byte_valid;
   logic [7:0]        rx_byte;
   logic              frame_err;
   logic              good_byte, bad_frame, is_sync;
   loader_state_t     state;
   logic [ADDR_W-1:0] idx;
   logic [7:0]        csum;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .byte_valid(byte_valid),
      .rx_byte   (rx_byte),
      .frame_err (frame_err)
   );

   assign good_byte = byte_valid & ~frame_err;
   assign bad_frame = byte_valid & frame_err;
   assign is_sync   = good_byte && (rx_byte == SYNC_BYTE);

   // The write strobe must coincide with byte_valid, so it is decoded rather than registered.
   assign prog           = (state == ST_LOAD) && good_byte;
   assign addr           = idx;
   assign programm_input = prog ? rx_byte : 8'h00;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         cpu_reset <= holds_cpu(state);
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (is_sync) begin
                  state      <= ST_LOAD;
                  idx        <= '0;
                  load_done  <= 1'b0;
                  load_error <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (bad_frame) begin
                  state      <= ST_ERROR;
                  load_error <= 1'b1;
               end else if (good_byte) begin
                  idx <= idx + 1'b1;
                  if (idx == LAST_IDX) state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (bad_frame) begin
                  state      <= ST_ERROR;
                  load_error <= 1'b1;
               end else if (good_byte) begin
                  if (rx_byte == csum) begin
                     state     <= ST_DONE;
                     load_done <= 1'b1;
                  end else begin
                     state      <= ST_ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Checksum is data: cleared by each sync byte, accumulated on every write.
   always_ff @(posedge clk) begin
      if ((state != ST_LOAD) && (state != ST_CHECK) && is_sync) csum <= 8'h00;
      else if (prog)                                             csum <= csum_add(csum, rx_byte);
   end

endmodule
